// File: rtl/spi_pkg.sv
// rtl/spi_pkg.sv - shared register map, bit positions and FSM state type for the SPI master
package spi_pkg;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_DIV  = 2'd2;
    localparam logic [1:0] ADDR_STAT = 2'd3;

    localparam int CTRL_CPOL   = 0;
    localparam int CTRL_CPHA   = 1;
    localparam int CTRL_LSB    = 2;
    localparam int CTRL_IRQ_EN = 3;
    localparam int CTRL_CS_LO  = 4;
    localparam int CTRL_CS_HI  = 7;

    localparam int STAT_BUSY = 0;
    localparam int STAT_RXV  = 1;
    localparam int STAT_OVR  = 2;
    localparam int STAT_COL  = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LEAD,
        ST_SHIFT,
        ST_TRAIL
    } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// rtl/spi_clk_div.sv - loadable down-counter producing one tick per SCLK half-period
module spi_clk_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [DIV_W-1:0] divisor,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;

    // Held at the divisor while cleared, so the first half-period after release is full length.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear || (cnt_q == '0)) begin
            cnt_q <= divisor;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tick = (cnt_q == '0) && !clear;

endmodule

// File: rtl/avalon_spi_master.sv
// rtl/avalon_spi_master.sv - Avalon-MM SPI master; SPI_IRQ_EN adds the rx_valid interrupt
module avalon_spi_master
    import spi_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int NUM_CS = 4,
    parameter int DIV_W  = 16
) (
    input  logic              csi_clk,
    input  logic              csi_reset_n,
    input  logic              avs_chipselect,
    input  logic [1:0]        avs_address,
    input  logic              avs_write_n,
    input  logic              avs_read_n,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              ins_irq,
    output logic [NUM_CS-1:0] coe_cs_n,
    output logic              coe_sclk,
    output logic              coe_mosi,
    input  logic              coe_miso
);

    localparam int HP_W = $clog2(2 * DATA_W);
    localparam logic [HP_W-1:0] HP_LAST = HP_W'(2 * DATA_W - 1);

    spi_state_t state_q, state_d;

    logic              cpol_q, cpha_q, lsb_q;
    logic [3:0]        cs_idx_q;
    logic [DIV_W-1:0]  div_q;
    logic              sclk_q, mosi_q;
    logic [DATA_W-1:0] tx_sr, rx_sr, rx_data_q;
    logic              rx_valid_q, overrun_q, collision_q;
    logic [HP_W-1:0]   hp_q;
    logic              irq_en;

    logic wr, rd, wr_data, wr_ctrl, wr_div, wr_stat, rd_data;
    logic busy, start, tick, edge_lead, edge_trail, done;
    logic sample, advance, cpol_d;
    logic unused_wdata;

    assign wr      = avs_chipselect && !avs_write_n;
    assign rd      = avs_chipselect && !avs_read_n;
    assign wr_data = wr && (avs_address == ADDR_DATA);
    assign wr_ctrl = wr && (avs_address == ADDR_CTRL);
    assign wr_div  = wr && (avs_address == ADDR_DIV);
    assign wr_stat = wr && (avs_address == ADDR_STAT);
    assign rd_data = rd && (avs_address == ADDR_DATA);

    assign busy         = (state_q != ST_IDLE);
    assign start        = wr_data && !busy;
    assign unused_wdata = ^avs_writedata;

    spi_clk_div #(.DIV_W(DIV_W)) u_clk_div (
        .clk     (csi_clk),
        .rst_n   (csi_reset_n),
        .clear   (state_q == ST_IDLE),
        .divisor (div_q),
        .tick    (tick)
    );

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        edge_lead  = 1'b0;
        edge_trail = 1'b0;
        done       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LEAD;
                end
            end
            ST_LEAD: begin
                if (tick) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (tick) begin
                    edge_lead  = !hp_q[0];
                    edge_trail = hp_q[0];
                    if (hp_q == HP_LAST) begin
                        state_d = ST_TRAIL;
                    end
                end
            end
            ST_TRAIL: begin
                if (tick) begin
                    state_d = ST_IDLE;
                    done    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // CPHA=1 leaves the first leading edge alone: bit 0 is already on MOSI from LEAD.
    assign sample  = cpha_q ? edge_trail : edge_lead;
    assign advance = cpha_q ? (edge_lead && (hp_q != '0)) : edge_trail;
    assign cpol_d  = wr_ctrl ? avs_writedata[CTRL_CPOL] : cpol_q;

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            cpol_q      <= 1'b0;
            cpha_q      <= 1'b0;
            lsb_q       <= 1'b0;
            cs_idx_q    <= '0;
            div_q       <= '0;
            sclk_q      <= 1'b0;
            mosi_q      <= 1'b1;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            collision_q <= 1'b0;
            hp_q        <= '0;
        end else begin
            if (wr_ctrl && !busy) begin
                cpol_q   <= avs_writedata[CTRL_CPOL];
                cpha_q   <= avs_writedata[CTRL_CPHA];
                lsb_q    <= avs_writedata[CTRL_LSB];
                cs_idx_q <= avs_writedata[CTRL_CS_HI:CTRL_CS_LO];
            end
            if (wr_div && !busy) begin
                div_q <= avs_writedata[DIV_W-1:0];
            end

            if (state_q == ST_IDLE) begin
                sclk_q <= cpol_d;
            end else if (edge_lead || edge_trail) begin
                sclk_q <= ~sclk_q;
            end

            if (start) begin
                tx_sr  <= avs_writedata[DATA_W-1:0];
                mosi_q <= lsb_q ? avs_writedata[0] : avs_writedata[DATA_W-1];
                hp_q   <= '0;
            end else if (edge_lead || edge_trail) begin
                hp_q <= hp_q + 1'b1;
            end

            if (advance) begin
                tx_sr  <= lsb_q ? (tx_sr >> 1) : (tx_sr << 1);
                mosi_q <= lsb_q ? tx_sr[1] : tx_sr[DATA_W-2];
            end
            if (sample) begin
                rx_sr <= lsb_q ? {coe_miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], coe_miso};
            end

            // A same-cycle RXDATA read sees the old word; completion keeps rx_valid set.
            if (done) begin
                mosi_q     <= 1'b1;
                rx_data_q  <= rx_sr;
                rx_valid_q <= 1'b1;
            end else if (rd_data) begin
                rx_valid_q <= 1'b0;
            end

            if (done && rx_valid_q) begin
                overrun_q <= 1'b1;
            end else if (wr_stat && avs_writedata[STAT_OVR]) begin
                overrun_q <= 1'b0;
            end

            if (wr_data && busy) begin
                collision_q <= 1'b1;
            end else if (wr_stat && avs_writedata[STAT_COL]) begin
                collision_q <= 1'b0;
            end
        end
    end

`ifdef SPI_IRQ_EN
    logic irq_en_q, irq_q;

    always_ff @(posedge csi_clk or negedge csi_reset_n) begin
        if (!csi_reset_n) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_ctrl && !busy) begin
                irq_en_q <= avs_writedata[CTRL_IRQ_EN];
            end
            irq_q <= rx_valid_q && irq_en_q;
        end
    end

    assign irq_en  = irq_en_q;
    assign ins_irq = irq_q;
`else
    assign irq_en  = 1'b0;
    assign ins_irq = 1'b0;
`endif

    always_comb begin
        coe_cs_n = '1;
        if (busy) begin
            for (int i = 0; i < NUM_CS; i++) begin
                if (cs_idx_q == 4'(i)) begin
                    coe_cs_n[i] = 1'b0;
                end
            end
        end
    end

    assign coe_sclk = sclk_q;
    assign coe_mosi = mosi_q;

    always_comb begin
        avs_readdata = '0;
        case (avs_address)
            ADDR_DATA: avs_readdata = 32'(rx_data_q);
            ADDR_CTRL: avs_readdata = 32'({cs_idx_q, irq_en, lsb_q, cpha_q, cpol_q});
            ADDR_DIV:  avs_readdata = 32'(div_q);
            ADDR_STAT: avs_readdata = 32'({collision_q, overrun_q, rx_valid_q, busy});
            default:   avs_readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_avalon_spi_master.sv
// tb/tb_avalon_spi_master.sv - directed self-checking bench for avalon_spi_master
module tb_avalon_spi_master;
    import spi_pkg::*;

    localparam int DATA_W = 8;
    localparam int NUM_CS = 4;
    localparam int DIV_W  = 16;

    logic              csi_clk = 1'b0;
    logic              csi_reset_n = 1'b0;
    logic              avs_chipselect = 1'b0;
    logic [1:0]        avs_address = ADDR_STAT;
    logic              avs_write_n = 1'b1;
    logic              avs_read_n = 1'b1;
    logic [31:0]       avs_writedata = '0;
    logic [31:0]       avs_readdata;
    logic              ins_irq;
    logic [NUM_CS-1:0] coe_cs_n;
    logic              coe_sclk, coe_mosi, coe_miso;

    avalon_spi_master #(.DATA_W(DATA_W), .NUM_CS(NUM_CS), .DIV_W(DIV_W)) dut (
        .csi_clk        (csi_clk),
        .csi_reset_n    (csi_reset_n),
        .avs_chipselect (avs_chipselect),
        .avs_address    (avs_address),
        .avs_write_n    (avs_write_n),
        .avs_read_n     (avs_read_n),
        .avs_writedata  (avs_writedata),
        .avs_readdata   (avs_readdata),
        .ins_irq        (ins_irq),
        .coe_cs_n       (coe_cs_n),
        .coe_sclk       (coe_sclk),
        .coe_mosi       (coe_mosi),
        .coe_miso       (coe_miso)
    );

    always #5 csi_clk = ~csi_clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // SPI slave model: drives s_word, captures MOSI MSB-first into s_rx.
    logic        tb_loop = 1'b0;
    logic        m_cpol = 1'b0, m_cpha = 1'b0, s_lsb = 1'b0, s_miso = 1'b0;
    logic [7:0]  s_word = 8'h00;
    logic [31:0] s_rx = '0;
    int          s_k = 0, s_nrx = 0;
    logic        cs_act;
    logic        irq_seen = 1'b0;

    assign cs_act   = (coe_cs_n != '1);
    assign coe_miso = tb_loop ? coe_mosi : s_miso;

    function automatic logic s_bit(input int k);
        logic [2:0] idx;
        if (k > 7) return 1'b0;
        idx = 3'(s_lsb ? k : 7 - k);
        return s_word[idx];
    endfunction

    always @(posedge cs_act) begin
        s_k   = 0;
        s_rx  = '0;
        s_nrx = 0;
        if (!m_cpha) s_miso = s_bit(0);
    end

    always @(coe_sclk) begin
        if (cs_act) begin
            if ((coe_sclk != m_cpol) != m_cpha) begin
                s_rx = {s_rx[30:0], coe_mosi};
                s_nrx++;
            end else if (m_cpha) begin
                s_miso = s_bit(s_k);
                s_k++;
            end else begin
                s_k++;
                s_miso = s_bit(s_k);
            end
        end
    end

    always @(posedge ins_irq) irq_seen = 1'b1;

    task automatic avs_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge csi_clk);
        avs_chipselect = 1'b1; avs_address = a; avs_write_n = 1'b0; avs_writedata = d;
        @(negedge csi_clk);
        avs_chipselect = 1'b0; avs_write_n = 1'b1; avs_address = ADDR_STAT;
        #1;
    endtask

    task automatic avs_rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge csi_clk);
        avs_chipselect = 1'b1; avs_address = a; avs_read_n = 1'b0;
        #1 d = avs_readdata;
        @(negedge csi_clk);
        avs_chipselect = 1'b0; avs_read_n = 1'b1; avs_address = ADDR_STAT;
        #1;
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] d);
        avs_address = a;
        #1 d = avs_readdata;
        avs_address = ADDR_STAT;
        #1;
    endtask

    int          x_busy, x_t1, x_t2, x_tog;
    logic [3:0]  x_cs;
    logic        x_mosi;
    logic [31:0] rd_v;

    task automatic wait_idle();
        logic prev;
        x_busy = 0; x_t1 = -1; x_t2 = -1; x_tog = 0;
        prev = coe_sclk;
        while (avs_readdata[STAT_BUSY] && x_busy < 5000) begin
            x_busy++;
            @(negedge csi_clk);
            #1;
            if (coe_sclk != prev) begin
                if (x_tog == 0) x_t1 = x_busy;
                else if (x_tog == 1) x_t2 = x_busy;
                x_tog++;
                prev = coe_sclk;
            end
        end
        if (x_busy >= 5000) check("busy_timeout", 32'(x_busy), 32'd0);
    endtask

    task automatic xfer(input logic [31:0] tx);
        avs_wr(ADDR_DATA, tx);
        x_cs   = coe_cs_n;
        x_mosi = coe_mosi;
        wait_idle();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge csi_clk);
        #1;
        check("rst_cs_n", 32'(coe_cs_n), 32'hF);
        check("rst_sclk", 32'(coe_sclk), 32'd0);
        check("rst_mosi", 32'(coe_mosi), 32'd1);
        check("rst_irq", 32'(ins_irq), 32'd0);
        @(negedge csi_clk);
        csi_reset_n = 1'b1;
        for (int a = 0; a < 4; a++) begin
            peek(2'(a), rd_v);
            check($sformatf("rst_reg%0d", a), rd_v, 32'd0);
        end

        // Mode 0, divisor 0, loopback, 0xA5.
        tb_loop = 1'b1;
        xfer(32'hA5);
        check("t1_busy_cycles", 32'(x_busy), 32'd18);
        check("t1_cs_n", 32'(x_cs), 32'hE);
        check("t1_mosi_bits", s_rx, 32'hA5);
        check("t1_nbits", 32'(s_nrx), 32'd8);
        check("t1_cs_release", 32'(coe_cs_n), 32'hF);
        peek(ADDR_STAT, rd_v);
        check("t1_stat_rxv", rd_v, 32'h2);
        avs_rd(ADDR_DATA, rd_v);
        check("t1_rxdata", rd_v, 32'hA5);
        peek(ADDR_STAT, rd_v);
        check("t1_stat_clr", rd_v, 32'h0);

        // All four modes, divisor 3, slave answers 0x3C.
        tb_loop = 1'b0;
        s_word  = 8'h3C;
        avs_wr(ADDR_DIV, 32'd3);
        for (int m = 0; m < 4; m++) begin
            m_cpol = m[0];
            m_cpha = m[1];
            avs_wr(ADDR_CTRL, 32'(m));
            repeat (2) @(negedge csi_clk);
            #1;
            check($sformatf("m%0d_sclk_idle", m), 32'(coe_sclk), 32'(m_cpol));
            xfer(32'h96);
            check($sformatf("m%0d_busy", m), 32'(x_busy), 32'd72);
            check($sformatf("m%0d_halfper", m), 32'(x_t2 - x_t1), 32'd4);
            check($sformatf("m%0d_toggles", m), 32'(x_tog), 32'd16);
            check($sformatf("m%0d_sclk_end", m), 32'(coe_sclk), 32'(m_cpol));
            check($sformatf("m%0d_mosi", m), s_rx, 32'h96);
            avs_rd(ADDR_DATA, rd_v);
            check($sformatf("m%0d_rxdata", m), rd_v, 32'h3C);
        end

        // LSB-first, CS index 2, loopback.
        m_cpol = 1'b0; m_cpha = 1'b0; tb_loop = 1'b1;
        avs_wr(ADDR_DIV, 32'd0);
        avs_wr(ADDR_CTRL, 32'h24);
        peek(ADDR_CTRL, rd_v);
        check("t3_ctrl", rd_v, 32'h24);
        xfer(32'h01);
        check("t3_first_bit", 32'(x_mosi), 32'd1);
        check("t3_cs_n", 32'(x_cs), 32'hB);
        check("t3_mosi_bits", s_rx, 32'h80);
        avs_rd(ADDR_DATA, rd_v);
        check("t3_rxdata", rd_v, 32'h01);

        // CS index beyond NUM_CS: no select, transfer still runs.
        avs_wr(ADDR_CTRL, 32'h50);
        xfer(32'h5A);
        check("t4_cs_none", 32'(x_cs), 32'hF);
        check("t4_busy", 32'(x_busy), 32'd18);
        avs_rd(ADDR_DATA, rd_v);
        check("t4_rxdata", rd_v, 32'h5A);

        // Collision, ignored config writes, overrun, W1C.
        avs_wr(ADDR_CTRL, 32'h00);
        avs_wr(ADDR_DATA, 32'h11);
        avs_wr(ADDR_DATA, 32'h22);
        avs_wr(ADDR_CTRL, 32'h03);
        avs_wr(ADDR_DIV, 32'd5);
        wait_idle();
        check("t5_mosi_first", s_rx, 32'h11);
        peek(ADDR_CTRL, rd_v);
        check("t5_ctrl_kept", rd_v, 32'h0);
        peek(ADDR_DIV, rd_v);
        check("t5_div_kept", rd_v, 32'h0);
        peek(ADDR_STAT, rd_v);
        check("t5_stat_col", rd_v, 32'hA);
        xfer(32'h33);
        peek(ADDR_STAT, rd_v);
        check("t5_stat_ovr", rd_v, 32'hE);
        avs_wr(ADDR_STAT, 32'h0C);
        peek(ADDR_STAT, rd_v);
        check("t5_stat_w1c", rd_v, 32'h2);
        avs_rd(ADDR_DATA, rd_v);
        check("t5_rxdata", rd_v, 32'h33);

        // Reset during SHIFT half-period 5 with CPOL=1.
        avs_wr(ADDR_DIV, 32'd3);
        avs_wr(ADDR_CTRL, 32'h01);
        m_cpol = 1'b1;
        avs_wr(ADDR_DATA, 32'hF0);
        repeat (24) @(negedge csi_clk);
        check("t6_in_xfer", 32'(coe_cs_n), 32'hE);
        csi_reset_n = 1'b0;
        #1;
        check("t6_cs_n", 32'(coe_cs_n), 32'hF);
        check("t6_sclk", 32'(coe_sclk), 32'd0);
        check("t6_mosi", 32'(coe_mosi), 32'd1);
        peek(ADDR_STAT, rd_v);
        check("t6_busy", rd_v, 32'h0);
        peek(ADDR_DATA, rd_v);
        check("t6_rxdata", rd_v, 32'h0);
        peek(ADDR_CTRL, rd_v);
        check("t6_ctrl", rd_v, 32'h0);
        @(negedge csi_clk);
        csi_reset_n = 1'b1;
        m_cpol = 1'b0;

        // Interrupt behaviour.
        avs_wr(ADDR_DIV, 32'd0);
        avs_wr(ADDR_CTRL, 32'h08);
        peek(ADDR_CTRL, rd_v);
`ifdef SPI_IRQ_EN
        check("t7_ctrl_irq_en", rd_v, 32'h08);
        xfer(32'h77);
        check("t7_irq_done_cyc", 32'(ins_irq), 32'd0);
        @(negedge csi_clk);
        #1;
        check("t7_irq_rise", 32'(ins_irq), 32'd1);
        avs_rd(ADDR_DATA, rd_v);
        check("t7_rxdata", rd_v, 32'h77);
        check("t7_irq_hold", 32'(ins_irq), 32'd1);
        @(negedge csi_clk);
        #1;
        check("t7_irq_fall", 32'(ins_irq), 32'd0);
`else
        check("t7_ctrl_irq_en", rd_v, 32'h00);
        xfer(32'h77);
        avs_rd(ADDR_DATA, rd_v);
        check("t7_rxdata", rd_v, 32'h77);
        check("t7_irq_never", 32'(irq_seen), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
